// File: rtl/rm_pkg.sv
// Shared constants, types and helpers for the binary rate multiplier.
package rm_pkg;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 16;

    typedef enum logic {
        RS_IDLE = 1'b0,
        RS_PEND = 1'b1
    } rate_state_t;

    function automatic logic [WIDTH_MAX-1:0] all_ones(input int w);
        logic [WIDTH_MAX-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH_MAX; i++) begin
            if (i < w) r[i] = 1'b1;
        end
        return r;
    endfunction

    // Weight i (toggles once per 2^(i+1) enables) is gated by rate bit w-1-i.
    function automatic int rate_bit(input int idx, input int w);
        return w - 1 - idx;
    endfunction

endpackage

// File: rtl/rate_multiplier_n_if.sv
// Rate-update handshake bundle between the rate source and the multiplier.
interface rate_multiplier_n_if #(
    parameter int WIDTH = 4
);

    logic [WIDTH-1:0] rate_in;
    logic             rate_vld;
    logic             mode;
    logic             rate_rdy;

    modport master (
        output rate_in,
        output rate_vld,
        output mode,
        input  rate_rdy
    );

    modport slave (
        input  rate_in,
        input  rate_vld,
        input  mode,
        output rate_rdy
    );

endinterface

// File: rtl/rm_weight_decode.sv
// One-hot weight decode of the pre-increment count: bit i marks the enable
// on which counter bit i rises. No bit is set at count = all-ones.
module rm_weight_decode #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] weight
);

    logic ones_below;

    always_comb begin
        weight     = '0;
        ones_below = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            weight[i]  = !count[i] && ones_below;
            ones_below = ones_below && count[i];
        end
    end

endmodule

// File: rtl/rate_multiplier_n.sv
// Binary rate multiplier: fires on rate_act of every 2^WIDTH enables, with a
// boundary-synchronised or immediate rate update and a per-period pulse tally.
//
// state   | meaning
// --------+-------------------------------------------------------------
// RS_IDLE | no update waiting; rate_rdy high
// RS_PEND | shadow holds a rate to apply at the next wrap or restart
module rate_multiplier_n
    import rm_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                  CLK,
    input  logic                  Clear_n,
    input  logic                  en,
    input  logic                  restart,
    rate_multiplier_n_if.slave    rate_bus,
    output logic                  pulse_out,
    output logic                  tc_out,
    output logic [WIDTH-1:0]      count,
    output logic [WIDTH-1:0]      rate_act,
    output logic [WIDTH-1:0]      last_total
);

    localparam logic [WIDTH_MAX-1:0] ONES_FULL = all_ones(WIDTH);
    localparam logic [WIDTH-1:0]     CNT_MAX   = ONES_FULL[WIDTH-1:0];

    rate_state_t      state_q, state_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] rate_act_d;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] weight;
    logic [WIDTH-1:0] rate_rev;
    logic             hit;
    logic             at_max;
    logic             wrap;
    logic             boundary;
    logic             accept;

    rm_weight_decode #(.WIDTH(WIDTH)) u_weight_decode (
        .count  (count),
        .weight (weight)
    );

    always_comb begin
        rate_rev = '0;
        for (int i = 0; i < WIDTH; i++) begin
            rate_rev[i] = rate_act[rate_bit(i, WIDTH)];
        end
    end

    assign hit      = en && (|(weight & rate_rev));
    assign at_max   = (count == CNT_MAX);
    assign wrap     = en && at_max && !restart;
    assign boundary = wrap || restart;

    assign rate_bus.rate_rdy = (state_q == RS_IDLE);
    assign accept            = rate_bus.rate_vld && rate_bus.rate_rdy;

    // An accept landing on a boundary skips the shadow and takes effect at once.
    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        rate_act_d = rate_act;
        unique case (state_q)
            RS_IDLE: begin
                if (accept) begin
                    if (rate_bus.mode || boundary) begin
                        rate_act_d = rate_bus.rate_in;
                    end else begin
                        shadow_d = rate_bus.rate_in;
                        state_d  = RS_PEND;
                    end
                end
            end
            RS_PEND: begin
                if (boundary) begin
                    rate_act_d = shadow_q;
                    state_d    = RS_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!Clear_n) begin
            state_q    <= RS_IDLE;
            shadow_q   <= '0;
            rate_act   <= '0;
            count      <= '0;
            acc_q      <= '0;
            last_total <= '0;
            pulse_out  <= 1'b0;
            tc_out     <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            rate_act <= rate_act_d;
            if (restart) begin
                count     <= '0;
                acc_q     <= '0;
                pulse_out <= 1'b0;
                tc_out    <= 1'b0;
            end else begin
                if (en) count <= count + 1'b1;
                pulse_out <= hit;
                tc_out    <= en && at_max;
                if (wrap) begin
                    last_total <= acc_q + {{(WIDTH-1){1'b0}}, hit};
                    acc_q      <= '0;
                end else if (hit) begin
                    acc_q <= acc_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rate_multiplier_n.sv
// Scoreboard bench for rate_multiplier_n at WIDTH=4.
module tb_rate_multiplier_n;

    localparam int W = 4;
    localparam int N = 16;

    logic         CLK = 1'b0;
    logic         Clear_n;
    logic         en;
    logic         restart;
    logic         pulse_out;
    logic         tc_out;
    logic [W-1:0] count;
    logic [W-1:0] rate_act;
    logic [W-1:0] last_total;

    rate_multiplier_n_if #(.WIDTH(W)) rate_bus ();

    rate_multiplier_n #(.WIDTH(W)) dut (
        .CLK        (CLK),
        .Clear_n    (Clear_n),
        .en         (en),
        .restart    (restart),
        .rate_bus   (rate_bus),
        .pulse_out  (pulse_out),
        .tc_out     (tc_out),
        .count      (count),
        .rate_act   (rate_act),
        .last_total (last_total)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic         pulse;
        logic         tc;
        logic [W-1:0] cnt;
        logic [W-1:0] rate;
        logic [W-1:0] last;
        logic         rdy;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_mis = 0;

    logic [W-1:0] m_count, m_rate, m_shadow, m_acc, m_last;
    logic         m_pend;
    logic         obs_pulse;
    logic [W-1:0] pre_count;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Lowest zero bit of c picks the weight; its rate bit is mirrored.
    function automatic logic model_hit(input logic [W-1:0] c, input logic [W-1:0] r);
        for (int i = 0; i < W; i++) begin
            if (!c[i]) return r[W-1-i];
        end
        return 1'b0;
    endfunction

    task automatic compare_out();
        exp_t x;
        if (sb_q.size() == 0) begin
            check_val("sb_empty", 32'(1), 32'(0));
        end else begin
            x = sb_q.pop_front();
            check_val("pulse_out",  32'(pulse_out),  32'(x.pulse));
            check_val("tc_out",     32'(tc_out),     32'(x.tc));
            check_val("count",      32'(count),      32'(x.cnt));
            check_val("rate_act",   32'(rate_act),   32'(x.rate));
            check_val("last_total", 32'(last_total), 32'(x.last));
            check_val("rate_rdy",   32'(rate_bus.rate_rdy), 32'(x.rdy));
        end
        obs_pulse = pulse_out;
    endtask

    task automatic step(input logic e, input logic rs, input logic vld,
                        input logic [W-1:0] rin, input logic md);
        exp_t x;
        logic h, wrap, bnd, accept;
        @(negedge CLK);
        Clear_n           = 1'b1;
        en                = e;
        restart           = rs;
        rate_bus.rate_vld = vld;
        rate_bus.rate_in  = rin;
        rate_bus.mode     = md;
        pre_count = m_count;
        h      = e && model_hit(m_count, m_rate);
        wrap   = e && (m_count == W'(N-1)) && !rs;
        bnd    = wrap || rs;
        accept = vld && !m_pend;
        if (rs) begin
            x.pulse = 1'b0;
            x.tc    = 1'b0;
            m_count = '0;
            m_acc   = '0;
        end else begin
            x.pulse = h;
            x.tc    = e && (m_count == W'(N-1));
            if (wrap) begin
                m_last = m_acc + W'(h);
                m_acc  = '0;
            end else if (h) begin
                m_acc = m_acc + 1'b1;
            end
            if (e) m_count = m_count + 1'b1;
        end
        if (accept) begin
            if (md || bnd) m_rate = rin;
            else begin
                m_shadow = rin;
                m_pend   = 1'b1;
            end
        end else if (m_pend && bnd) begin
            m_rate = m_shadow;
            m_pend = 1'b0;
        end
        x.cnt  = m_count;
        x.rate = m_rate;
        x.last = m_last;
        x.rdy  = !m_pend;
        sb_q.push_back(x);
        @(posedge CLK);
        #1;
        compare_out();
    endtask

    // Reset is driven against busy inputs to show it overrides them.
    task automatic do_reset();
        exp_t x;
        @(negedge CLK);
        Clear_n           = 1'b0;
        en                = 1'b1;
        restart           = 1'b0;
        rate_bus.rate_vld = 1'b1;
        rate_bus.rate_in  = 4'd7;
        rate_bus.mode     = 1'b1;
        m_count = '0; m_rate = '0; m_shadow = '0; m_acc = '0; m_last = '0; m_pend = 1'b0;
        x.pulse = 1'b0; x.tc = 1'b0; x.cnt = '0; x.rate = '0; x.last = '0; x.rdy = 1'b1;
        sb_q.push_back(x);
        @(posedge CLK);
        #1;
        compare_out();
        @(negedge CLK);
        Clear_n           = 1'b1;
        en                = 1'b0;
        rate_bus.rate_vld = 1'b0;
    endtask

    task automatic run_period(output logic [N-1:0] mask, output int tcs);
        mask = '0;
        tcs  = 0;
        for (int k = 0; k < N; k++) begin
            step(1'b1, 1'b0, 1'b0, '0, 1'b0);
            if (obs_pulse) mask[pre_count] = 1'b1;
            if (tc_out) tcs++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [N-1:0] mask;
        int           tcs;

        Clear_n = 1'b0; en = 1'b0; restart = 1'b0;
        rate_bus.rate_vld = 1'b0; rate_bus.rate_in = '0; rate_bus.mode = 1'b0;
        repeat (2) @(posedge CLK);
        do_reset();

        // Immediate load of rate 5, one full period.
        step(1'b0, 1'b0, 1'b1, 4'd5, 1'b1);
        run_period(mask, tcs);
        check_val("s1_mask", 32'(mask), 32'h22A2);
        check_val("s1_tc",   32'(tcs), 32'(1));
        check_val("s1_last", 32'(last_total), 32'(5));

        // Maximum and zero rates.
        step(1'b0, 1'b0, 1'b1, 4'd15, 1'b1);
        run_period(mask, tcs);
        check_val("s2_mask15", 32'(mask), 32'h7FFF);
        check_val("s2_last15", 32'(last_total), 32'(15));
        step(1'b0, 1'b0, 1'b1, 4'd0, 1'b1);
        run_period(mask, tcs);
        check_val("s2_mask0", 32'(mask), 32'h0000);
        check_val("s2_last0", 32'(last_total), 32'(0));

        // Boundary-synchronised write of 8 issued at count 3.
        step(1'b0, 1'b0, 1'b1, 4'd5, 1'b1);
        mask = '0;
        for (int c = 0; c < N; c++) begin
            step(1'b1, 1'b0, (c == 3), 4'd8, 1'b0);
            if (obs_pulse) mask[pre_count] = 1'b1;
            if (c >= 3 && c < N-1) check_val("s3_rdy_low", 32'(rate_bus.rate_rdy), 32'(0));
        end
        check_val("s3_old_mask", 32'(mask), 32'h22A2);
        check_val("s3_old_last", 32'(last_total), 32'(5));
        check_val("s3_rdy_back", 32'(rate_bus.rate_rdy), 32'(1));
        check_val("s3_rate",     32'(rate_act), 32'(8));
        run_period(mask, tcs);
        check_val("s3_new_mask", 32'(mask), 32'h5555);
        check_val("s3_new_last", 32'(last_total), 32'(8));

        // Deferred write landing on the wrap cycle applies at once.
        for (int c = 0; c < N-1; c++) step(1'b1, 1'b0, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 4'd3, 1'b0);
        check_val("s4_rate", 32'(rate_act), 32'(3));
        check_val("s4_rdy",  32'(rate_bus.rate_rdy), 32'(1));
        check_val("s4_cnt",  32'(count), 32'(0));

        // Enable toggling with rate 5 spreads one period over 32 cycles.
        step(1'b0, 1'b0, 1'b1, 4'd5, 1'b1);
        mask = '0;
        for (int k = 0; k < 2*N; k++) begin
            step((k % 2 == 0), 1'b0, 1'b0, '0, 1'b0);
            if (k % 2 == 0) begin
                if (obs_pulse) mask[pre_count] = 1'b1;
            end else begin
                check_val("s5_idle_pulse", 32'(obs_pulse), 32'(0));
            end
        end
        check_val("s5_mask", 32'(mask), 32'h22A2);
        check_val("s5_last", 32'(last_total), 32'(5));

        // Restart at count 9 with a pending write of 3.
        for (int c = 0; c < 9; c++) step(1'b1, 1'b0, (c == 2), 4'd3, 1'b0);
        check_val("s6_pend", 32'(rate_bus.rate_rdy), 32'(0));
        step(1'b1, 1'b1, 1'b0, '0, 1'b0);
        check_val("s6_cnt",  32'(count), 32'(0));
        check_val("s6_rate", 32'(rate_act), 32'(3));
        check_val("s6_last", 32'(last_total), 32'(5));

        // Mid-period reset with an update pending.
        for (int c = 0; c < 5; c++) step(1'b1, 1'b0, (c == 1), 4'd9, 1'b0);
        do_reset();
        check_val("s6_rst_cnt",  32'(count), 32'(0));
        check_val("s6_rst_rate", 32'(rate_act), 32'(0));
        check_val("s6_rst_rdy",  32'(rate_bus.rate_rdy), 32'(1));
        step(1'b1, 1'b0, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, 1'b0, '0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
